// File: rtl/ps_sync_ctrl_pkg.sv
// Shared program-state definitions used by the fetch-side sync controller
// and the MMU ASID tracker.
package ps_sync_ctrl_pkg;

   typedef struct packed {
      logic [1:0]  priv;
      logic        isa_c;
      logic        mie;
      logic        sie;
      logic        trans;
      logic [8:0]  asid;
      logic [21:0] base;
   } program_state_t;

   localparam int PS_W = 37;

   localparam logic [PS_W-1:0] PS_IE_MASK   = {2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 9'h000, 22'h000000};
   localparam logic [PS_W-1:0] PS_CTX_MASK  = {2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 9'h000, 22'h000000};
   localparam logic [PS_W-1:0] PS_XLAT_MASK = {2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 9'h1FF, 22'h3FFFFF};

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      FLUSH   = 2'd1,
      RELEASE = 2'd2
   } ps_sync_state_e;

   function automatic program_state_t ps_reset_value(input logic [1:0] priv, input logic isa_c);
      program_state_t v;
      v       = 37'h0;
      v.priv  = priv;
      v.isa_c = isa_c;
      return v;
   endfunction

   function automatic logic ps_masked_diff(input program_state_t a, input program_state_t b,
                                           input logic [PS_W-1:0] mask);
      return |((a ^ b) & mask);
   endfunction

endpackage

// File: rtl/ps_diff_classify.sv
// Classifies the difference between two program states into interrupt-enable,
// context (priv/isa_c) and translation (trans/asid/base) changes.
module ps_diff_classify
   import ps_sync_ctrl_pkg::*;
(
   input  program_state_t i_old,
   input  program_state_t i_new,
   output logic           o_ie_diff,
   output logic           o_ctx_diff,
   output logic           o_xlat_diff
);

   assign o_ie_diff   = ps_masked_diff(i_old, i_new, PS_IE_MASK);
   assign o_ctx_diff  = ps_masked_diff(i_old, i_new, PS_CTX_MASK);
   assign o_xlat_diff = ps_masked_diff(i_old, i_new, PS_XLAT_MASK);

endmodule

// File: rtl/ps_sync_ctrl.sv
// Holds the stable program state seen by fetch/MMU; context and translation
// changes only land after a pipeline/TLB flush handshake completes.
module ps_sync_ctrl
   import ps_sync_ctrl_pkg::*;
#(
   parameter logic [1:0]  RESET_PRIV  = 2'b11,
   parameter logic        RESET_ISA_C = 1'b1,
   parameter int unsigned ACK_TIMEOUT = 64
) (
   input  logic           i_clk,
   input  logic           i_rst_n,
   input  program_state_t i_ps,
   output program_state_t o_ps,
   output logic           o_stall_fetch,
   output logic           o_flush_pipe,
   output logic           o_flush_tlb,
   input  logic           i_flush_ack,
   output logic           o_timeout,
   input  logic [31:0]    i_log_fd
);

   localparam int             CW      = $clog2(ACK_TIMEOUT + 1);
   localparam logic [CW-1:0]  CNT_MAX = CW'(ACK_TIMEOUT);
   localparam logic [CW-1:0]  CNT_TRG = CW'(ACK_TIMEOUT - 1);

   ps_sync_state_e r_state;
   program_state_t r_ps;
   logic [CW-1:0]  r_cnt;
   logic           r_stall;
   logic           r_flush_pipe;
   logic           r_flush_tlb;
   logic           r_timeout;

   logic           w_ie;
   logic           w_ctx;
   logic           w_xlat;
   logic           w_need_flush;

   ps_diff_classify u_classify (
      .i_old       (r_ps),
      .i_new       (i_ps),
      .o_ie_diff   (w_ie),
      .o_ctx_diff  (w_ctx),
      .o_xlat_diff (w_xlat)
   );

   assign w_need_flush = w_ctx | w_xlat;

   // Flush handshake FSM; IE bits bypass it, everything else lands on the ack edge.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state      <= IDLE;
         r_ps         <= ps_reset_value(RESET_PRIV, RESET_ISA_C);
         r_cnt        <= {CW{1'b0}};
         r_stall      <= 1'b0;
         r_flush_pipe <= 1'b0;
         r_flush_tlb  <= 1'b0;
         r_timeout    <= 1'b0;
      end else begin
         if (w_ie) begin
            r_ps.mie <= i_ps.mie;
            r_ps.sie <= i_ps.sie;
         end
         case (r_state)
            IDLE, RELEASE: begin
               if (w_need_flush) begin
                  r_state      <= FLUSH;
                  r_stall      <= 1'b1;
                  r_flush_pipe <= 1'b1;
                  r_flush_tlb  <= w_xlat;
                  r_cnt        <= {CW{1'b0}};
               end else begin
                  r_state <= IDLE;
                  r_stall <= 1'b0;
               end
            end
            FLUSH: begin
               if (i_flush_ack) begin
                  r_ps         <= i_ps;
                  r_flush_pipe <= 1'b0;
                  r_flush_tlb  <= 1'b0;
                  r_state      <= RELEASE;
               end else begin
                  r_flush_tlb <= r_flush_tlb | w_xlat;
                  if (r_cnt != CNT_MAX) begin
                     r_cnt <= r_cnt + CW'(1);
                  end
                  if (r_cnt == CNT_TRG) begin
                     r_timeout <= 1'b1;
                  end
               end
            end
            default: begin
               r_state      <= IDLE;
               r_stall      <= 1'b0;
               r_flush_pipe <= 1'b0;
               r_flush_tlb  <= 1'b0;
            end
         endcase
      end
   end

   assign o_ps          = r_ps;
   assign o_stall_fetch = r_stall;
   assign o_flush_pipe  = r_flush_pipe;
   assign o_flush_tlb   = r_flush_tlb;
   assign o_timeout     = r_timeout;

`ifndef SYNTHESIS
   // Simulation trace of flush entries and acks with old and new state.
   always @(posedge i_clk) begin
      if (i_rst_n && (i_log_fd != 32'd0)) begin
         if ((r_state != FLUSH) && w_need_flush) begin
            $display("ps_sync_ctrl: enter flush old=%h new=%h", r_ps, i_ps);
         end
         if ((r_state == FLUSH) && i_flush_ack) begin
            $display("ps_sync_ctrl: flush ack old=%h new=%h", r_ps, i_ps);
         end
      end
   end
`endif

endmodule

// File: tb/tb_ps_sync_ctrl.sv
// Directed bench for ps_sync_ctrl: a behavioural model tracks the expected
// outputs every cycle, plus hand-computed literal checks at key points.
module tb_ps_sync_ctrl;

   localparam logic [36:0] RST_PS = {2'b11, 1'b1, 34'h0};
   localparam logic [36:0] B_CTX  = {3'b111, 34'h0};
   localparam logic [36:0] B_XL   = {5'b00000, 32'hFFFF_FFFF};

   logic        clk = 1'b0;
   logic        rst_n;
   logic [36:0] ps;
   logic        ack;
   logic [31:0] log_fd;
   logic [36:0] o_ps;
   logic        o_stall;
   logic        o_pipe;
   logic        o_tlb;
   logic        o_timeout;

   int n_checks = 0;
   int n_fail   = 0;

   // model state
   bit          m_valid = 1'b0;
   logic [36:0] m_ps;
   int          m_phase;
   int          m_wait;
   logic        m_stall, m_pipe, m_tlb, m_timeout;

   always #5 clk = ~clk;

   ps_sync_ctrl #(
      .RESET_PRIV  (2'b11),
      .RESET_ISA_C (1'b1),
      .ACK_TIMEOUT (64)
   ) dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_ps          (ps),
      .o_ps          (o_ps),
      .o_stall_fetch (o_stall),
      .o_flush_pipe  (o_pipe),
      .o_flush_tlb   (o_tlb),
      .i_flush_ack   (ack),
      .o_timeout     (o_timeout),
      .i_log_fd      (log_fd)
   );

   // Model: phase 0 = settled, 1 = waiting for ack, 2 = one cycle after ack.
   always @(posedge clk) begin : model
      logic [36:0] d;
      logic [36:0] nps;
      logic        cx;
      logic        xl;
      if (!rst_n) begin
         m_ps      <= RST_PS;
         m_phase   <= 0;
         m_wait    <= 0;
         m_stall   <= 1'b0;
         m_pipe    <= 1'b0;
         m_tlb     <= 1'b0;
         m_timeout <= 1'b0;
         m_valid   <= 1'b1;
      end else begin
         d   = ps ^ m_ps;
         cx  = |(d & B_CTX);
         xl  = |(d & B_XL);
         nps = m_ps;
         nps[33:32] = ps[33:32];
         if (m_phase == 1) begin
            if (ack) begin
               nps = ps;
               m_pipe  <= 1'b0;
               m_tlb   <= 1'b0;
               m_phase <= 2;
            end else begin
               m_tlb  <= m_tlb | xl;
               m_wait <= m_wait + 1;
               if (m_wait + 1 >= 64) m_timeout <= 1'b1;
            end
         end else if (cx || xl) begin
            m_phase <= 1;
            m_stall <= 1'b1;
            m_pipe  <= 1'b1;
            m_tlb   <= xl;
            m_wait  <= 0;
         end else begin
            m_phase <= 0;
            m_stall <= 1'b0;
         end
         m_ps <= nps;
      end
   end

   task automatic chk(input string nm, input logic [36:0] act, input logic [36:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Advance n cycles, comparing against the model on each falling edge.
   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (m_valid) begin
            chk("model_ps", o_ps, m_ps);
            chk("model_stall", {36'h0, o_stall}, {36'h0, m_stall});
            chk("model_pipe", {36'h0, o_pipe}, {36'h0, m_pipe});
            chk("model_tlb", {36'h0, o_tlb}, {36'h0, m_tlb});
            chk("model_timeout", {36'h0, o_timeout}, {36'h0, m_timeout});
         end
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      rst_n  = 1'b0;
      ps     = RST_PS;
      ack    = 1'b0;
      log_fd = 32'd0;
      tick(2);
      chk("rst_ps", o_ps, {2'b11, 1'b1, 34'h0});
      chk("rst_ctrl", {33'h0, o_stall, o_pipe, o_tlb, o_timeout}, 37'h0);
      rst_n = 1'b1;
      tick(2);
      chk("idle_ps", o_ps, RST_PS);
      chk("idle_ctrl", {33'h0, o_stall, o_pipe, o_tlb, o_timeout}, 37'h0);

      // IE-only change: immediate, never stalls
      ps[33] = 1'b1;
      tick(1);
      chk("mie_follow", {36'h0, o_ps[33]}, 37'h1);
      chk("mie_no_stall", {35'h0, o_stall, o_pipe}, 37'h0);
      tick(2);
      chk("mie_no_flush", {35'h0, o_stall, o_pipe}, 37'h0);

      // priv 3->0, ack on cycle 5
      ps[36:35] = 2'b00;
      tick(1);
      chk("priv_req", {34'h0, o_stall, o_pipe, o_tlb}, {34'h0, 3'b110});
      chk("priv_hold", {35'h0, o_ps[36:35]}, {35'h0, 2'b11});
      tick(3);
      ack = 1'b1;
      tick(1);
      ack = 1'b0;
      chk("priv_new", {35'h0, o_ps[36:35]}, 37'h0);
      chk("priv_rel", {35'h0, o_stall, o_pipe}, {35'h0, 2'b10});
      tick(1);
      chk("priv_unstall", {36'h0, o_stall}, 37'h0);

      // asid then base, coalesced into one TLB flush
      ps[31]    = 1'b1;
      ps[30:22] = 9'h005;
      tick(1);
      chk("asid_req", {35'h0, o_pipe, o_tlb}, {35'h0, 2'b11});
      tick(1);
      ps[21:0] = 22'h012345;
      tick(2);
      chk("coalesce_hold", {35'h0, o_pipe, o_tlb}, {35'h0, 2'b11});
      ack = 1'b1;
      tick(1);
      ack = 1'b0;
      chk("coalesce_ps", o_ps, {2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 9'h005, 22'h012345});
      tick(1);
      chk("coalesce_done", {35'h0, o_stall, o_pipe}, 37'h0);

      // satp change in the ack cycle of a priv-only flush
      ps[36:35] = 2'b01;
      tick(1);
      chk("ctx_only_tlb", {36'h0, o_tlb}, 37'h0);
      tick(1);
      ack       = 1'b1;
      ps[30:22] = 9'h00A;
      ps[21:0]  = 22'h2AAAA;
      tick(1);
      ack = 1'b0;
      chk("same_cycle_ps", o_ps, ps);
      tick(1);
      chk("same_cycle_no_reflush", {35'h0, o_stall, o_pipe}, 37'h0);
      tick(1);

      // satp change one cycle after ack: re-flush from RELEASE
      ps[36:35] = 2'b11;
      tick(2);
      ack = 1'b1;
      tick(1);
      ack       = 1'b0;
      ps[30:22] = 9'h011;
      tick(1);
      chk("reflush", {34'h0, o_stall, o_pipe, o_tlb}, {34'h0, 3'b111});
      chk("reflush_old_asid", {28'h0, o_ps[30:22]}, {28'h0, 9'h00A});
      tick(1);
      ack = 1'b1;
      tick(1);
      ack = 1'b0;
      chk("reflush_ps", o_ps, ps);
      tick(1);
      chk("reflush_done", {36'h0, o_stall}, 37'h0);

      // stray ack while idle
      ack = 1'b1;
      tick(1);
      ack = 1'b0;
      chk("idle_ack", {35'h0, o_stall, o_pipe}, 37'h0);

      // timeout
      ps[36:35] = 2'b00;
      tick(1);
      tick(63);
      chk("timeout_early", {36'h0, o_timeout}, 37'h0);
      tick(1);
      chk("timeout_set", {35'h0, o_timeout, o_pipe}, {35'h0, 2'b11});
      tick(4);
      ack = 1'b1;
      tick(1);
      ack = 1'b0;
      chk("timeout_sticky", {35'h0, o_timeout, o_pipe}, {35'h0, 2'b10});
      tick(1);
      ps[34] = 1'b0;
      tick(3);
      chk("flush_again", {35'h0, o_pipe, o_timeout}, {35'h0, 2'b11});

      // reset mid-flush, then a late ack
      rst_n = 1'b0;
      tick(1);
      chk("midrst_ps", o_ps, RST_PS);
      chk("midrst_ctrl", {33'h0, o_stall, o_pipe, o_tlb, o_timeout}, 37'h0);
      ps    = RST_PS;
      rst_n = 1'b1;
      ack   = 1'b1;
      tick(1);
      ack = 1'b0;
      tick(1);
      chk("late_ack_ps", o_ps, RST_PS);
      chk("late_ack_ctrl", {33'h0, o_stall, o_pipe, o_tlb, o_timeout}, 37'h0);
      tick(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ps_sync_ctrl.md
Name: ps_sync_ctrl

Overview:
- Sits directly downstream of the program-state packer. Consumes the packed program_state_t and produces the stable copy seen by fetch and the I/D MMUs.
- Detects changes in the program state and classifies each one. Interrupt-enable changes apply immediately. Privilege, ISA-C and translation changes first go through a pipeline/TLB flush handshake, and only then reach fetch.
- Guarantees that no instruction is fetched under a half-applied translation context.

Parameters:
- RESET_PRIV, 2'b11, privilege level driven on o_ps after reset (M-mode).
- RESET_ISA_C, 1'b1, compressed-enable bit after reset.
- ACK_TIMEOUT, 64, cycles to wait for i_flush_ack before raising o_timeout; must be ≥2.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  synchronous active-low reset.
- i_ps  in  program_state_t (37)  live program state {priv[2], isa_c, mie, sie, trans, asid[9], base[22]}.
- o_ps  out  program_state_t (37)  stable program state for fetch/MMU.
- o_stall_fetch  out  1  fetch must not issue new requests.
- o_flush_pipe  out  1  pipeline flush request; held until acknowledged.
- o_flush_tlb  out  1  TLB flush request; valid only while o_flush_pipe=1.
- i_flush_ack  in  1  single-cycle ack that the flush has completed.
- o_timeout  out  1  sticky: ack not received within ACK_TIMEOUT cycles.
- i_log_fd  in  32  log file descriptor for simulation trace only; no RTL effect.

Behaviour:
- Reset (i_rst_n=0 at posedge):
  - o_ps = {RESET_PRIV, RESET_ISA_C, 0, 0, 0, 9'h0, 22'h0}.
  - o_stall_fetch=0, o_flush_pipe=0, o_flush_tlb=0, o_timeout=0, state=IDLE, timeout counter=0.
  - Reset mid-flush aborts the handshake immediately. A later i_flush_ack is ignored.
- Field classes, comparing i_ps against o_ps:
  - IE-only: only mie/sie differ.
  - CTX: priv or isa_c differ.
  - XLAT: trans, asid or base differ.
- IE fields (mie, sie) always follow i_ps with 1-cycle latency, in every state, never stalled.
- States: IDLE, FLUSH, RELEASE.
- IDLE:
  - If CTX or XLAT differ: go to FLUSH next cycle. Assert o_stall_fetch=1 and o_flush_pipe=1 (registered). Set o_flush_tlb=1 iff XLAT differs. Clear the counter.
  - o_ps priv/isa_c/trans/asid/base are not updated yet.
- FLUSH:
  - Hold o_flush_pipe and o_stall_fetch.
  - o_flush_tlb becomes sticky-OR with any XLAT difference that appears while waiting.
  - Counter increments each cycle. When it reaches ACK_TIMEOUT, set o_timeout=1 (sticky until reset). Remain in FLUSH.
  - On i_flush_ack=1: capture all of i_ps into o_ps on that edge. Deassert o_flush_pipe and o_flush_tlb. Go to RELEASE.
  - i_flush_ack in IDLE or RELEASE is ignored.
- RELEASE (exactly 1 cycle):
  - o_stall_fetch stays 1.
  - If i_ps CTX or XLAT now differ from o_ps (a change landed in the ack cycle): go to FLUSH again with fresh classification.
  - Otherwise go to IDLE and deassert o_stall_fetch.
- Latency:
  - Change-to-request: 1 cycle.
  - Ack to new o_ps visible: 1 cycle.
  - Ack to fetch unstall: 2 cycles minimum.
- Simultaneous events:
  - i_ps change in the same cycle as i_flush_ack: the captured o_ps takes the new value, and RELEASE then sees no difference.
  - Multiple changes during FLUSH coalesce into one flush. o_ps always ends equal to i_ps at the ack edge.
- Sim-only: when i_log_fd≠0, $fdisplay each transition to FLUSH and each ack, with old and new ps.

Decomposition:
- Shared ps package holds:
  - program_state_t, with field accessors.
  - PS_IE_MASK, PS_CTX_MASK, PS_XLAT_MASK 37-bit constants.
  - ps_sync_state_e enum {IDLE, FLUSH, RELEASE}.
- One natural sub-module: ps_diff_classify, a combinational unit taking (old, new) and returning {ie_diff, ctx_diff, xlat_diff}. It is reused by the MMU's ASID-tracking logic.

Test Plan:
- Release reset → o_ps priv=2'b11, isa_c=1, all other fields 0; all control outputs 0.
- Change only i_ps.mie 0→1 → o_ps.mie=1 next cycle; o_stall_fetch and o_flush_pipe stay 0 throughout.
- Change priv 3→0 → next cycle o_flush_pipe=1, o_flush_tlb=0, o_stall_fetch=1. Ack on cycle 5 → o_ps.priv=0 cycle 6; o_stall_fetch=0 cycle 7.
- Change asid 0→9'h05 with trans=1, then base change 2 cycles later with no new request → single flush with o_flush_tlb=1. After one ack, o_ps holds both new asid and base.
- Change satp in the same cycle as the ack of a priv-only flush → o_ps captures the new satp and no second flush occurs. Repeat with the change one cycle after the ack → FLUSH re-entered from RELEASE with o_flush_tlb=1.
- Withhold ack with ACK_TIMEOUT=64 → o_timeout=1 on cycle 64 of FLUSH, stays 1 after a late ack. Assert reset mid-FLUSH → all outputs at reset values next cycle.
